pipelined_register_file: RTL

Parametrised MIPS general-purpose register file for the pipelined core: one write port, two combinational read ports, $zero hardwired to 0, and a $sp reset value derived from data-memory depth. It adds a per-register pending scoreboard for load-use and writeback hazard detection, and a multi-cycle soft-clear sequencer. It sits in the decode stage, written from writeback and reserved from issue.

---
 rtl/pipelined_register_file_if.sv | 37 +++
 rtl/pipelined_register_file.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pipelined_register_file_if.sv
// Decode-stage register file bus: writeback write port, issue reservation,
// two read ports with pending flags, and the soft-clear handshake.
interface pipelined_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  reg_write_i;
  logic [ADDR_WIDTH-1:0] write_register_i;
  logic [DATA_WIDTH-1:0] write_data_i;
  logic [ADDR_WIDTH-1:0] read_register_1_i;
  logic [ADDR_WIDTH-1:0] read_register_2_i;
  logic [DATA_WIDTH-1:0] read_data_1_o;
  logic [DATA_WIDTH-1:0] read_data_2_o;
  logic                  read_pending_1_o;
  logic                  read_pending_2_o;
  logic                  reserve_i;
  logic [ADDR_WIDTH-1:0] reserve_register_i;
  logic                  clear_i;
  logic                  busy_o;
  logic                  clear_done_o;

  modport master (
    output reg_write_i, write_register_i, write_data_i,
    output read_register_1_i, read_register_2_i,
    output reserve_i, reserve_register_i, clear_i,
    input  read_data_1_o, read_data_2_o, read_pending_1_o, read_pending_2_o,
    input  busy_o, clear_done_o
  );

  modport slave (
    input  reg_write_i, write_register_i, write_data_i,
    input  read_register_1_i, read_register_2_i,
    input  reserve_i, reserve_register_i, clear_i,
    output read_data_1_o, read_data_2_o, read_pending_1_o, read_pending_2_o,
    output busy_o, clear_done_o
  );
endinterface

// File: rtl/pipelined_register_file.sv
// MIPS GPR file with pending scoreboard and multi-cycle soft-clear sweep.
// Optional write-through read forwarding is enabled by defining REGFILE_BYPASS_EN.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | normal operation: writes, reserves and clear requests accepted
//   ST_CLEAR | sweeping idx 1..NUM_REGS-1 back to reset values; inputs dropped
module pipelined_register_file #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int MEMORY_DEPTH = 32,
  parameter int SP_INDEX     = 29,
  parameter logic [DATA_WIDTH-1:0] SP_INIT = DATA_WIDTH'(32'h1001_0000 + MEMORY_DEPTH * 4)
) (
  input  logic clk,
  input  logic reset,
  pipelined_register_file_if.slave rf
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q, pend_d;
  logic                  done_q, done_d;

  logic                  wr_ok;
  logic                  rsv_ok;
  logic [DATA_WIDTH-1:0] rd_1, rd_2;
  logic                  rp_1, rp_2;

  assign wr_ok  = rf.reg_write_i && (state_q == ST_IDLE) && (rf.write_register_i != ZERO_IDX);
  assign rsv_ok = rf.reserve_i   && (state_q == ST_IDLE) && (rf.reserve_register_i != ZERO_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_INIT : '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    regs_d  = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_ok) begin
          regs_d[rf.write_register_i] = rf.write_data_i;
          pend_d[rf.write_register_i] = 1'b0;
        end
        // Reserve after write: a freshly issued producer outranks the retiring one.
        if (rsv_ok) begin
          pend_d[rf.reserve_register_i] = 1'b1;
        end
        if (rf.clear_i) begin
          state_d = ST_CLEAR;
          pend_d  = '0;
          idx_d   = ADDR_WIDTH'(1);
        end
      end

      ST_CLEAR: begin
        regs_d[idx_q] = (int'(idx_q) == SP_INDEX) ? SP_INIT : '0;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    rd_1 = regs_q[rf.read_register_1_i];
    rp_1 = pend_q[rf.read_register_1_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (rf.write_register_i == rf.read_register_1_i)) begin
      rd_1 = rf.write_data_i;
      rp_1 = rsv_ok && (rf.reserve_register_i == rf.read_register_1_i);
    end
`endif
  end

  always_comb begin
    rd_2 = regs_q[rf.read_register_2_i];
    rp_2 = pend_q[rf.read_register_2_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (rf.write_register_i == rf.read_register_2_i)) begin
      rd_2 = rf.write_data_i;
      rp_2 = rsv_ok && (rf.reserve_register_i == rf.read_register_2_i);
    end
`endif
  end

  assign rf.read_data_1_o    = rd_1;
  assign rf.read_data_2_o    = rd_2;
  assign rf.read_pending_1_o = rp_1;
  assign rf.read_pending_2_o = rp_2;
  assign rf.busy_o           = (state_q == ST_CLEAR);
  assign rf.clear_done_o     = done_q;

endmodule
